bf_pass_sequencer: RTL and testbench
====================================

# bf_pass_sequencer

Top-level pass controller for the Bellman-Ford engine. It reads the source node and node count from Input Memory and initialises the distance array in Output Memory. It then schedules relaxation passes on the edge-relaxation datapath through a start/done handshake, runs one detection pass, and reports `Finish` or `NegCycle`.

## Interface
Parameters:
- `ADDR_W`, 13: memory address width.
- `DIST_W`, 16: distance word width.
- `NODE_W`, 8: node index/count width (Input Memory data width).
- `INF`, 16'hFFFF: unreachable distance.
- `SRC_ADDR`, 0: Input Memory address holding the source node.
- `CNT_ADDR`, 1: Input Memory address holding the node count N.

Ports:
- `clock`: in, 1. Single clock; all state changes on the rising edge.
- `reset`: in, 1. Asynchronous, active-low.
- `start`: in, 1. Single-cycle pulse; sampled only in IDLE.
- `IMAR`: out, ADDR_W. Input Memory read address; the read is combinational.
- `IMDR`: in, NODE_W. Input Memory read data.
- `OMWAR`: out, ADDR_W. Output Memory write address.
- `OMWDR`: out, DIST_W. Output Memory write data.
- `OMWE`: out, 1. Output Memory write enable; the write is synchronous.
- `pass_start`: out, 1. One-cycle pulse that launches one full edge pass.
- `pass_check`: out, 1. High with `pass_start` for the detection pass only.
- `pass_index`: out, NODE_W. Current pass number, 1-based.
- `pass_done`: in, 1. One-cycle pulse from the datapath when a pass completes.
- `pass_changed`: in, 1. Qualified by `pass_done`: at least one distance was updated.
- `node_count`: out, NODE_W. Latched N, for the datapath.
- `source_node`: out, NODE_W. Latched source, for the datapath.
- `busy`: out, 1. High in every state except IDLE, DONE and NEG.
- `Finish`: out, 1. Level; held until reset or a new `start`.
- `NegCycle`: out, 1. Level; held until reset or a new `start`.

## Operation
States: IDLE, RD_SRC, RD_CNT, INIT, PASS_REQ, PASS_WAIT, CHK_REQ, CHK_WAIT, DONE, NEG.
- **IDLE**: on `start`, clear `Finish`, `NegCycle` and `pass_index`, then go to RD_SRC. `start` is also accepted in DONE and NEG, with the same effect. `start` in any other state is ignored.
- **RD_SRC**: `IMAR`=SRC_ADDR; latch `IMDR` into `source_node`.
- **RD_CNT**: `IMAR`=CNT_ADDR; latch `IMDR` into `node_count`.
  - N=0: go to DONE with no writes.
  - Otherwise: go to INIT.
- **INIT**: counter i from 0 to N-1, one write per cycle.
  - `OMWE`=1, `OMWAR`=i, `OMWDR` = 0 when i==source, else INF.
  - If source ≥ N, every entry is INF; after INIT go straight to DONE.
  - After i=N-1: N=1 goes to DONE; otherwise go to PASS_REQ.
- **PASS_REQ**: increment `pass_index`, pulse `pass_start` for one cycle, go to PASS_WAIT.
- **PASS_WAIT**: wait for `pass_done`.
  - If `pass_index` == N-1, go to CHK_REQ.
  - Else go to PASS_REQ (subject to EARLY_EXIT_EN, see Configuration).
- **CHK_REQ**: pulse `pass_start` and `pass_check` together for one cycle, go to CHK_WAIT.
- **CHK_WAIT**: on `pass_done`: `pass_changed`=1 goes to NEG, else DONE.
- **DONE**: `Finish`=1.
- **NEG**: `NegCycle`=1; `Finish` stays 0.
- `pass_done` is ignored outside PASS_WAIT and CHK_WAIT.
- `pass_index` saturates at N-1 and never wraps.

## Timing
- Reset values: `IMAR`, `OMWAR`, `OMWDR`, `node_count`, `source_node` and `pass_index` are 0. `OMWE`, `pass_start`, `pass_check`, `busy`, `Finish` and `NegCycle` are 0. State is IDLE.
- Reset asserted mid-operation aborts immediately. Outputs return to reset values asynchronously, so no further `OMWE` occurs.
- Cycle budget:
  - `start` to first `OMWE`: 3 cycles.
  - INIT: exactly N cycles.
  - Last INIT write to `pass_start`: 1 cycle.
- `pass_done` is registered: the next `pass_start` comes at least 2 cycles after a `pass_done`.
- If `pass_done` arrives in the same cycle as `pass_start`, it is not sampled.
- `Finish` and `NegCycle` rise on the cycle after the terminal `pass_done` (or after the last INIT/RD_CNT cycle in the trivial cases). They are never high together.

## Configuration
- `BF_EARLY_EXIT_EN` defined: in PASS_WAIT, `pass_done` with `pass_changed`=0 goes directly to DONE. The remaining relaxation passes and the detection pass are skipped, because a converged graph has no negative cycle.
- `BF_EARLY_EXIT_EN` undefined: exactly N-1 relaxation passes plus one detection pass always run. `pass_changed` is examined only in CHK_WAIT.

## Structure
- Shared package `bf_pkg` holds:
  - the state enum;
  - the `INF` constant;
  - `SRC_ADDR` and `CNT_ADDR`;
  - the width constants shared with the datapath and memories.
- Sub-module `bf_init_writer` is natural: it holds the INIT counter and generates the Output Memory write. Its interface is go/N/source in and a done pulse out.
- The FSM stays in `bf_pass_sequencer`.

## Test plan
- **Normal run, no early exit.** Source=2, N=5; datapath reports changed=1, 1, 1, 0 and check pass changed=0.
  - INIT writes FFFF, FFFF, 0, FFFF, FFFF to addresses 0–4.
  - 4 `pass_start` pulses with `pass_index` 1–4, then one check pulse, then `Finish`=1.
- **Negative cycle.** Same setup, check pass `pass_changed`=1 → `NegCycle`=1, `Finish`=0.
- **Early exit (`BF_EARLY_EXIT_EN`).** N=5, pass 2 reports changed=0 → `Finish` after exactly 2 passes and no check pulse.
- **Trivial sizes.**
  - N=0 → `Finish` 3 cycles after `start`, no `OMWE`.
  - N=1, source=0 → one write of 0 to address 0, then `Finish`, no `pass_start`.
- **Source out of range.** Source=9, N=4 → four INF writes, `Finish`, no passes.
- **Reset mid-run.** `reset` low during PASS_WAIT → all outputs 0 immediately. A later `start` reruns from RD_SRC.

Source files
------------

// File: rtl/bf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bf_pkg
// Description : Shared types and constants for the Bellman-Ford engine:
//               sequencer state enum, unreachable-distance value, Input
//               Memory header addresses and the width constants shared by
//               the sequencer, the edge-relaxation datapath and the memories.
// Revision    : 1.0 - initial release
// ============================================================================
package bf_pkg;

    localparam int BF_ADDR_W = 13;      // memory address width
    localparam int BF_DIST_W = 16;      // distance word width
    localparam int BF_NODE_W = 8;       // node index / count width

    localparam logic [BF_DIST_W-1:0] BF_INF      = 16'hFFFF;
    localparam logic [BF_ADDR_W-1:0] BF_SRC_ADDR = 13'd0;
    localparam logic [BF_ADDR_W-1:0] BF_CNT_ADDR = 13'd1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RD_SRC    = 4'd1,
        ST_RD_CNT    = 4'd2,
        ST_INIT      = 4'd3,
        ST_PASS_REQ  = 4'd4,
        ST_PASS_WAIT = 4'd5,
        ST_CHK_REQ   = 4'd6,
        ST_CHK_WAIT  = 4'd7,
        ST_DONE      = 4'd8,
        ST_NEG       = 4'd9
    } bf_state_e;

endpackage : bf_pkg
`default_nettype wire

// File: rtl/bf_init_writer.sv
`default_nettype none
// ============================================================================
// Module      : bf_init_writer
// Description : Distance-array initialiser. While go is high it emits one
//               Output Memory write per cycle for i = 0 .. node_count-1,
//               writing 0 at the source index and INF everywhere else.
//               done is high during the cycle of the last write.
// Ports       : clock, reset (async, active-low)
//               go          - in : held high for the whole INIT phase
//               node_count  - in : N (non-zero whenever go is high)
//               source_node - in : source index
//               we/waddr/wdata - out: Output Memory write port (0 when idle)
//               done        - out: last-write indicator
// Revision    : 1.0 - initial release
// ============================================================================
module bf_init_writer
    import bf_pkg::*;
#(
    parameter int                 ADDR_W = BF_ADDR_W,
    parameter int                 DIST_W = BF_DIST_W,
    parameter int                 NODE_W = BF_NODE_W,
    parameter logic [DIST_W-1:0]  INF    = BF_INF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic [NODE_W-1:0] node_count,
    input  logic [NODE_W-1:0] source_node,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DIST_W-1:0] wdata,
    output logic              done
);

    logic [NODE_W-1:0] r_idx;
    logic              w_last;

    assign w_last = (r_idx == node_count - NODE_W'(1));

    // Counter parks at 0 whenever go is low so every INIT phase starts at i=0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
        end else if (go && !w_last) begin
            r_idx <= r_idx + NODE_W'(1);
        end else begin
            r_idx <= '0;
        end
    end

    // Address/data are forced to 0 outside INIT so the port idles at its
    // reset value.
    always_comb begin
        we    = go;
        waddr = '0;
        wdata = '0;
        done  = go && w_last;
        if (go) begin
            waddr = ADDR_W'(r_idx);
            wdata = (r_idx == source_node) ? '0 : INF;
        end
    end

endmodule : bf_init_writer
`default_nettype wire

// File: rtl/bf_pass_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bf_pass_sequencer
// Description : Bellman-Ford pass controller. Reads source and N from Input
//               Memory, initialises the distance array, launches N-1
//               relaxation passes plus one detection pass on the datapath and
//               reports Finish or NegCycle.
// Ports       : clock, reset (async, active-low), start
//               IMAR/IMDR          - Input Memory combinational read
//               OMWAR/OMWDR/OMWE   - Output Memory synchronous write
//               pass_start/pass_check/pass_index - pass launch to datapath
//               pass_done/pass_changed           - pass completion from datapath
//               node_count/source_node           - latched N and source
//               busy, Finish, NegCycle           - status
// Config      : BF_EARLY_EXIT_EN - when defined, a relaxation pass that
//               changes nothing ends the run with Finish immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module bf_pass_sequencer
    import bf_pkg::*;
#(
    parameter int                 ADDR_W   = BF_ADDR_W,
    parameter int                 DIST_W   = BF_DIST_W,
    parameter int                 NODE_W   = BF_NODE_W,
    parameter logic [DIST_W-1:0]  INF      = BF_INF,
    parameter logic [ADDR_W-1:0]  SRC_ADDR = BF_SRC_ADDR,
    parameter logic [ADDR_W-1:0]  CNT_ADDR = BF_CNT_ADDR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] IMAR,
    input  logic [NODE_W-1:0] IMDR,
    output logic [ADDR_W-1:0] OMWAR,
    output logic [DIST_W-1:0] OMWDR,
    output logic              OMWE,
    output logic              pass_start,
    output logic              pass_check,
    output logic [NODE_W-1:0] pass_index,
    input  logic              pass_done,
    input  logic              pass_changed,
    output logic [NODE_W-1:0] node_count,
    output logic [NODE_W-1:0] source_node,
    output logic              busy,
    output logic              Finish,
    output logic              NegCycle
);

    bf_state_e         r_state;
    bf_state_e         w_next;
    logic [NODE_W-1:0] r_source;
    logic [NODE_W-1:0] r_count;
    logic [NODE_W-1:0] r_pass_index;
    logic              r_done_q;
    logic              w_accept;
    logic              w_init_go;
    logic              w_init_done;
    logic              w_last_pass;

    assign w_accept    = start && (r_state == ST_IDLE || r_state == ST_DONE ||
                                   r_state == ST_NEG);
    assign w_init_go   = (r_state == ST_INIT);
    assign w_last_pass = (r_pass_index == r_count - NODE_W'(1));

    bf_init_writer #(
        .ADDR_W (ADDR_W),
        .DIST_W (DIST_W),
        .NODE_W (NODE_W),
        .INF    (INF)
    ) u_init_writer (
        .clock       (clock),
        .reset       (reset),
        .go          (w_init_go),
        .node_count  (r_count),
        .source_node (r_source),
        .we          (OMWE),
        .waddr       (OMWAR),
        .wdata       (OMWDR),
        .done        (w_init_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_source     <= '0;
            r_count      <= '0;
            r_pass_index <= '0;
            r_done_q     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_RD_SRC) begin
                r_source <= IMDR;
            end
            if (r_state == ST_RD_CNT) begin
                r_count <= IMDR;
            end
            // Index is bumped on entry to PASS_REQ so it is already valid
            // while pass_start is high; it never passes N-1.
            if (w_accept) begin
                r_pass_index <= '0;
            end else if (w_next == ST_PASS_REQ && !w_last_pass) begin
                r_pass_index <= r_pass_index + NODE_W'(1);
            end
            // A non-terminal pass_done is held for one cycle before the next
            // request, keeping two cycles between pass_done and pass_start.
            r_done_q <= (r_state == ST_PASS_WAIT) && (w_next == ST_PASS_WAIT) &&
                        pass_done;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_RD_SRC;
            end
            ST_RD_SRC: begin
                w_next = ST_RD_CNT;
            end
            ST_RD_CNT: begin
                w_next = (IMDR == '0) ? ST_DONE : ST_INIT;
            end
            ST_INIT: begin
                if (w_init_done) begin
                    if (r_source >= r_count || r_count == NODE_W'(1)) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_PASS_REQ;
                    end
                end
            end
            ST_PASS_REQ: begin
                w_next = ST_PASS_WAIT;
            end
            ST_PASS_WAIT: begin
                if (r_done_q) begin
                    w_next = w_last_pass ? ST_CHK_REQ : ST_PASS_REQ;
                end
`ifdef BF_EARLY_EXIT_EN
                else if (pass_done && !pass_changed) begin
                    w_next = ST_DONE;
                end
`endif
            end
            ST_CHK_REQ: begin
                w_next = ST_CHK_WAIT;
            end
            ST_CHK_WAIT: begin
                if (pass_done) w_next = pass_changed ? ST_NEG : ST_DONE;
            end
            ST_DONE, ST_NEG: begin
                if (w_accept) w_next = ST_RD_SRC;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        IMAR        = (r_state == ST_RD_CNT) ? CNT_ADDR : SRC_ADDR;
        pass_start  = (r_state == ST_PASS_REQ) || (r_state == ST_CHK_REQ);
        pass_check  = (r_state == ST_CHK_REQ);
        pass_index  = r_pass_index;
        node_count  = r_count;
        source_node = r_source;
        busy        = !(r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_NEG);
        Finish      = (r_state == ST_DONE);
        NegCycle    = (r_state == ST_NEG);
    end

endmodule : bf_pass_sequencer
`default_nettype wire

// File: tb/tb_bf_pass_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bf_pass_sequencer
// Description : Self-checking bench for bf_pass_sequencer. For every run the
//               bench builds the expected per-cycle output timeline from the
//               source/N/datapath response it chooses, plays the datapath
//               and Input Memory, and compares all outputs every cycle.
//               Honours BF_EARLY_EXIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bf_pass_sequencer;

    localparam int ADDR_W = 13;
    localparam int DIST_W = 16;
    localparam int NODE_W = 8;
    localparam int TMAX   = 256;
`ifdef BF_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              pass_done = 1'b0;
    logic              pass_changed = 1'b0;
    logic [ADDR_W-1:0] IMAR;
    logic [NODE_W-1:0] IMDR;
    logic [ADDR_W-1:0] OMWAR;
    logic [DIST_W-1:0] OMWDR;
    logic              OMWE, pass_start, pass_check, busy, Finish, NegCycle;
    logic [NODE_W-1:0] pass_index, node_count, source_node;

    logic [NODE_W-1:0] mem_src = '0;
    logic [NODE_W-1:0] mem_n   = '0;

    bf_pass_sequencer dut (
        .clock(clock), .reset(reset), .start(start),
        .IMAR(IMAR), .IMDR(IMDR),
        .OMWAR(OMWAR), .OMWDR(OMWDR), .OMWE(OMWE),
        .pass_start(pass_start), .pass_check(pass_check), .pass_index(pass_index),
        .pass_done(pass_done), .pass_changed(pass_changed),
        .node_count(node_count), .source_node(source_node),
        .busy(busy), .Finish(Finish), .NegCycle(NegCycle)
    );

    always #5 clock = ~clock;

    // Input Memory: header words only, combinational read.
    always_comb begin
        IMDR = '0;
        if (IMAR == 13'd0) IMDR = mem_src;
        else if (IMAR == 13'd1) IMDR = mem_n;
    end

    int total = 0;
    int bad   = 0;

    // Expected timeline, indexed by cycle since start (cycle 0 = start high).
    bit e_we[TMAX], e_ps[TMAX], e_pc[TMAX], e_busy[TMAX], e_fin[TMAX], e_neg[TMAX];
    int e_addr[TMAX], e_data[TMAX], e_idx[TMAX];
    bit d_done[TMAX], d_chg[TMAX];
    int lat_a[16];
    bit chg_a[16];
    int t_end, t_term, cur_src, cur_n;
    int cyc = 0;
    bit active = 1'b0;
    int obs_we, obs_ps, obs_chk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_imar"}, IMAR, 0);
        chk({tag, "_omwar"}, OMWAR, 0);
        chk({tag, "_omwdr"}, OMWDR, 0);
        chk({tag, "_omwe"}, OMWE, 0);
        chk({tag, "_pstart"}, pass_start, 0);
        chk({tag, "_pcheck"}, pass_check, 0);
        chk({tag, "_pidx"}, pass_index, 0);
        chk({tag, "_ncnt"}, node_count, 0);
        chk({tag, "_srcn"}, source_node, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fin"}, Finish, 0);
        chk({tag, "_neg"}, NegCycle, 0);
    endtask

    // Build the expected timeline from the operational rules.
    task automatic build(input int src, input int n, input bit spur);
        int t, k, p, lat, term, cur;
        bit chg, neg, isck;
        for (int u = 0; u < TMAX; u++) begin
            e_we[u] = 0; e_ps[u] = 0; e_pc[u] = 0; e_busy[u] = 0;
            e_fin[u] = 0; e_neg[u] = 0; e_addr[u] = 0; e_data[u] = 0;
            e_idx[u] = 0; d_done[u] = 0; d_chg[u] = 0;
        end
        t = 3; term = 3; neg = 0;
        if (n > 0) begin
            for (int i = 0; i < n; i++) begin
                e_we[t] = 1; e_addr[t] = i; e_data[t] = (i == src) ? 0 : 32'hFFFF;
                t++;
            end
            term = t;
            if (src < n && n > 1) begin
                p = 1; k = 0;
                while (1) begin
                    isck = (p > n - 1);
                    lat = lat_a[k]; chg = chg_a[k]; k++;
                    e_ps[t] = 1; e_pc[t] = isck;
                    if (!isck) e_idx[t] = p;
                    if (spur) d_done[t] = 1;   // must be ignored: same cycle as pass_start
                    d_done[t+lat] = 1; d_chg[t+lat] = chg;
                    if (isck) begin term = t + lat + 1; neg = chg; break; end
                    if (EARLY && !chg) begin term = t + lat + 1; break; end
                    t = t + lat + 2; p++;
                end
            end
        end
        for (int u = 1; u < term; u++) e_busy[u] = 1;
        for (int u = term; u <= term + 2; u++) begin e_fin[u] = !neg; e_neg[u] = neg; end
        t_term = term;
        t_end  = term + 2;
        cur = 0;
        for (int u = 1; u <= t_end; u++) begin
            if (e_ps[u] && !e_pc[u]) cur = e_idx[u];
            e_idx[u] = cur;
        end
    endtask

    task automatic run(input int src, input int n, input bit spur, input int abort_at);
        build(src, n, spur);
        mem_src = NODE_W'(src); mem_n = NODE_W'(n);
        cur_src = src; cur_n = n;
        obs_we = 0; obs_ps = 0; obs_chk = 0;
        @(posedge clock); #1;
        cyc = 0; active = 1'b1;
        for (int t = 0; t <= t_end; t++) begin
            if (t > 0) begin @(posedge clock); #1; cyc = t; end
            start        = (t == 0);
            pass_done    = d_done[t];
            pass_changed = d_chg[t];
            if (t == abort_at) begin
                #2;
                active = 1'b0; reset = 1'b0; pass_done = 1'b0;
                #1;
                check_zero("rst_mid");
                @(posedge clock); #1;
                reset = 1'b1;
                return;
            end
        end
        @(posedge clock); #1;
        active = 1'b0; start = 1'b0; pass_done = 1'b0; pass_changed = 1'b0;
    endtask

    task automatic set_resp(input int lat, input bit c0, input bit c1, input bit c2,
                            input bit c3, input bit c4);
        for (int k = 0; k < 16; k++) begin lat_a[k] = lat; chg_a[k] = 1'b0; end
        chg_a[0] = c0; chg_a[1] = c1; chg_a[2] = c2; chg_a[3] = c3; chg_a[4] = c4;
    endtask

    // Per-cycle comparison against the timeline.
    always @(negedge clock) begin
        if (active && cyc >= 1) begin
            chk("busy", busy, e_busy[cyc]);
            chk("omwe", OMWE, e_we[cyc]);
            if (e_we[cyc]) begin
                chk("omwar", OMWAR, e_addr[cyc]);
                chk("omwdr", OMWDR, e_data[cyc]);
            end
            chk("pass_start", pass_start, e_ps[cyc]);
            chk("pass_check", pass_check, e_pc[cyc]);
            chk("pass_index", pass_index, e_idx[cyc]);
            chk("finish", Finish, e_fin[cyc]);
            chk("negcycle", NegCycle, e_neg[cyc]);
            if (cyc == 1) chk("imar_src", IMAR, 0);
            if (cyc == 2) chk("imar_cnt", IMAR, 1);
            if (cyc >= 2) chk("source_node", source_node, cur_src);
            if (cyc >= 3) chk("node_count", node_count, cur_n);
            if (OMWE === 1'b1) obs_we++;
            if (pass_start === 1'b1) obs_ps++;
            if (pass_check === 1'b1) obs_chk++;
        end
    end

    initial begin
        #2;
        check_zero("rst");
        #10;
        reset = 1'b1;

        // Normal run: source 2, N 5, changed 1,1,1,0 then check 0.
        set_resp(1, 1, 1, 1, 0, 0);
        build(2, 5, 1'b0);
        chk("model_w0", e_data[3], 32'hFFFF);
        chk("model_w2", e_data[5], 0);
        chk("model_ps1", e_ps[8], 1);
        chk("model_idx2", e_idx[11], 2);
        chk("model_term", t_term, EARLY ? 19 : 22);
        run(2, 5, 1'b0, -1);
        chk("norm_writes", obs_we, 5);
        chk("norm_starts", obs_ps, EARLY ? 4 : 5);
        chk("norm_checks", obs_chk, EARLY ? 0 : 1);
        chk("norm_fin", Finish, 1);
        chk("norm_neg", NegCycle, 0);

        // Negative cycle: every pass changes, detection pass changes.
        set_resp(2, 1, 1, 1, 1, 1);
        run(2, 5, 1'b1, -1);
        chk("neg_starts", obs_ps, 5);
        chk("neg_checks", obs_chk, 1);
        chk("neg_neg", NegCycle, 1);
        chk("neg_fin", Finish, 0);

        // Early convergence on pass 2.
        set_resp(1, 1, 0, 0, 0, 0);
        run(1, 5, 1'b0, -1);
        chk("early_starts", obs_ps, EARLY ? 2 : 5);
        chk("early_checks", obs_chk, EARLY ? 0 : 1);
        chk("early_fin", Finish, 1);

        // Trivial sizes and out-of-range source.
        run(0, 0, 1'b0, -1);
        chk("n0_term", t_term, 3);
        chk("n0_writes", obs_we, 0);
        chk("n0_fin", Finish, 1);
        run(0, 1, 1'b0, -1);
        chk("n1_writes", obs_we, 1);
        chk("n1_starts", obs_ps, 0);
        run(9, 4, 1'b0, -1);
        chk("oor_writes", obs_we, 4);
        chk("oor_starts", obs_ps, 0);
        chk("oor_fin", Finish, 1);

        // Reset during the first PASS_WAIT cycle, then a clean rerun.
        set_resp(3, 1, 1, 1, 1, 0);
        run(2, 5, 1'b0, 9);
        set_resp(1, 1, 1, 0, 1, 0);
        run(3, 5, 1'b0, -1);
        chk("rerun_writes", obs_we, 5);

        // Randomized runs.
        for (int r = 0; r < 60; r++) begin
            for (int k = 0; k < 16; k++) begin
                lat_a[k] = $urandom_range(1, 4);
                chg_a[k] = ($urandom_range(0, 3) != 0);
            end
            run($urandom_range(0, 8), $urandom_range(0, 7), 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bf_pass_sequencer
`default_nettype wire
